// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: SPI register offsets, command code, sequencer states and config packing
package spi_seq_pkg;
  localparam logic [15:0] OFS_CONFIG = 16'h0000;
  localparam logic [15:0] OFS_TX = 16'h0004;
  localparam logic [15:0] OFS_CMD = 16'h000C;
  localparam logic [15:0] OFS_STATUS = 16'h0000;
  localparam logic [15:0] OFS_RX = 16'h0004;
  localparam logic [7:0] CMD_START = 8'h02;
  typedef enum logic [3:0] {
    S_IDLE, S_CFG_WR, S_TX_WR, S_CMD_WR, S_POLL_WAIT, S_STAT_RD, S_RX_RD, S_NEXT, S_DONE
  } state_t;
  function automatic logic [7:0] cfg_byte(input logic [1:0] mode, input logic [1:0] slave, input logic [1:0] sck);
    return {2'b00, mode, slave, sck};
  endfunction
endpackage

// File: rtl/apb_master_xfer.sv
// apb_master_xfer: single APB transfer engine (req -> SETUP -> ACCESS until pready, ack/rdata on completion)
module apb_master_xfer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [7:0]  pwdata,
  input  logic [7:0]  prdata,
  input  logic        pready
);
  assign ack = psel && penable && pready;
  assign rdata = prdata;
  always_ff @(posedge clk)
    if (rst) begin
      psel <= 1'b0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
    end else if (!psel) begin
      if (req) begin
        psel <= 1'b1;
        pwrite <= write;
        paddr <= addr;
        pwdata <= wdata;
      end
    end else if (!penable) penable <= 1'b1;
    else if (pready) begin
      psel <= 1'b0;
      penable <= 1'b0;
    end
endmodule

// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: APB master sequencing up to 8 SPI byte transfers (CONFIG once, then TX/CMD/poll STATUS/RX per byte)
module spi_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0040,
  parameter int BUSY_BIT = 0,
  parameter int POLL_GAP = 8,
  parameter int POLL_MAX = 255
) (
  input  logic        i_PCLK,
  input  logic        i_PRESET,
  input  logic        i_start,
  input  logic [1:0]  i_mode,
  input  logic [1:0]  i_slave,
  input  logic [1:0]  i_sck,
  input  logic [3:0]  i_nbytes,
  input  logic [63:0] i_tx_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [63:0] o_rx_data,
  output logic        o_PSEL,
  output logic        o_PENABLE,
  output logic        o_PWRITE,
  output logic [15:0] o_PADDR,
  output logic [7:0]  o_PWDATA,
  input  logic [7:0]  i_PRDATA,
  input  logic        i_PREADY
);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  state_t state;
  logic [7:0] cfg, wdata, rdata;
  logic [63:0] tx;
  logic [3:0] left;
  logic [GW-1:0] gap;
  logic [PW-1:0] polls;
  logic [15:0] ofs;
  logic req, write, ack, gap_end;
  assign gap_end = gap == GW'(POLL_GAP - 1);
  always_comb begin
    req = state inside {S_CFG_WR, S_TX_WR, S_CMD_WR, S_RX_RD} || (state == S_POLL_WAIT && gap_end);
    write = state inside {S_CFG_WR, S_TX_WR, S_CMD_WR};
    ofs = state == S_CFG_WR ? OFS_CONFIG : state == S_TX_WR ? OFS_TX : state == S_CMD_WR ? OFS_CMD :
          state == S_RX_RD ? OFS_RX : OFS_STATUS;
    wdata = state == S_CFG_WR ? cfg : state == S_TX_WR ? tx[63:56] : state == S_CMD_WR ? CMD_START : 8'h00;
  end
  apb_master_xfer u_apb (
    .clk(i_PCLK),
    .rst(i_PRESET),
    .req(req),
    .write(write),
    .addr(BASE_ADDR + ofs),
    .wdata(wdata),
    .ack(ack),
    .rdata(rdata),
    .psel(o_PSEL),
    .penable(o_PENABLE),
    .pwrite(o_PWRITE),
    .paddr(o_PADDR),
    .pwdata(o_PWDATA),
    .prdata(i_PRDATA),
    .pready(i_PREADY)
  );
  always_ff @(posedge i_PCLK)
    if (i_PRESET) begin
      state <= S_IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
      o_rx_data <= '0;
      cfg <= '0;
      tx <= '0;
      left <= '0;
      gap <= '0;
      polls <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          cfg <= cfg_byte(i_mode, i_slave, i_sck);
          tx <= i_tx_data;
          left <= i_nbytes > 4'd8 ? 4'd8 : i_nbytes;
          o_rx_data <= '0;
          o_err <= 1'b0;
          o_busy <= 1'b1;
          state <= i_nbytes == 4'd0 ? S_DONE : S_CFG_WR;
        end
        S_CFG_WR: if (ack) state <= S_TX_WR;
        S_TX_WR: if (ack) state <= S_CMD_WR;
        S_CMD_WR: if (ack) begin
          gap <= '0;
          polls <= '0;
          state <= S_POLL_WAIT;
        end
        S_POLL_WAIT: if (gap_end) state <= S_STAT_RD;
          else gap <= gap + 1'b1;
        S_STAT_RD: if (ack) begin
          if (!rdata[BUSY_BIT]) state <= S_RX_RD;
          else if (polls == PW'(POLL_MAX - 1)) begin
            o_err <= 1'b1;
            state <= S_DONE;
          end else begin
            polls <= polls + 1'b1;
            gap <= '0;
            state <= S_POLL_WAIT;
          end
        end
        S_RX_RD: if (ack) begin
          o_rx_data <= {o_rx_data[55:0], rdata};
          left <= left - 1'b1;
          state <= S_NEXT;
        end
        S_NEXT: begin
          tx <= tx << 8;
          state <= left == 4'd0 ? S_DONE : S_TX_WR;
        end
        S_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// tb_spi_burst_sequencer: scoreboard bench with an APB slave model for spi_burst_sequencer
module tb_spi_burst_sequencer;
  localparam int GAP = 8;
  localparam int PMAX = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] mode = '0, slave = '0, sck = '0;
  logic [3:0] nbytes = '0;
  logic [63:0] tx_data = '0;
  logic busy, done, err, psel, penable, pwrite;
  logic [63:0] rx_data;
  logic [15:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata = '0;
  logic pready = 1'b0;
  int vecs = 0, errs = 0;
  logic [24:0] exp_apb[$];
  logic [64:0] exp_res[$];
  int ws = 0, busy_n = 0;
  bit stuck = 0, rx_inv = 0, sb_on = 0;
  int wcnt = 0, scnt = 0;
  logic [7:0] last_tx = '0;
  int gapc = 0, psel_cyc = 0, done_cnt = 0;
  logic [24:0] setup_snap = '0;
  bit unstable = 0;

  always #5 clk = ~clk;

  spi_burst_sequencer #(.POLL_MAX(PMAX)) dut (
    .i_PCLK(clk),
    .i_PRESET(rst),
    .i_start(start),
    .i_mode(mode),
    .i_slave(slave),
    .i_sck(sck),
    .i_nbytes(nbytes),
    .i_tx_data(tx_data),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .o_rx_data(rx_data),
    .o_PSEL(psel),
    .o_PENABLE(penable),
    .o_PWRITE(pwrite),
    .o_PADDR(paddr),
    .o_PWDATA(pwdata),
    .i_PRDATA(prdata),
    .i_PREADY(pready)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // APB slave: wait states, STATUS busy for busy_n reads per byte (or forever), RX = 3C or ~TX
  always @(posedge clk) begin
    if (psel && penable && pready) begin
      wcnt = 0;
      if (pwrite && paddr == 16'h0044) last_tx = pwdata;
      if (pwrite && paddr == 16'h004C) scnt = 0;
      if (!pwrite && paddr == 16'h0040) scnt = scnt + 1;
    end else if (psel && penable) wcnt++;
    else wcnt = 0;
    #2;
    pready = psel && penable && wcnt >= ws;
    prdata = paddr == 16'h0040 ? ((stuck || scnt < busy_n) ? 8'h01 : 8'h00) : (rx_inv ? ~last_tx : 8'h3C);
  end

  // monitor: pops expected APB transfers and burst results as the DUT presents them
  always @(negedge clk) begin
    logic [24:0] e;
    logic [64:0] r;
    psel_cyc += int'(psel);
    if (done) done_cnt++;
    if (sb_on) begin
      if (psel && !penable) begin
        setup_snap = {pwrite, paddr, pwdata};
        unstable = 0;
        if (!pwrite && paddr == 16'h0040) chk("status_gap", gapc, GAP);
      end
      if (psel && penable && {pwrite, paddr, pwdata} != setup_snap) unstable = 1;
      if (psel && penable && pready) begin
        if (exp_apb.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL apb_extra: got %b@%h=%h expected no transfer", pwrite, paddr, pwdata);
        end else begin
          e = exp_apb.pop_front();
          chk("apb_xfer", {pwrite, paddr, pwrite ? pwdata : 8'h00}, e);
        end
        chk("apb_stable", unstable, 0);
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL done_extra: got done=1 expected 0");
        end else begin
          r = exp_res.pop_front();
          chk("burst_result", {err, rx_data}, r);
          chk("busy_at_done", busy, 0);
        end
      end
    end
    gapc = psel ? 0 : gapc + 1;
  end

  task automatic burst(input int n, input logic [63:0] txd, input logic [1:0] m, input logic [1:0] s,
                       input logic [1:0] k, input int bn, input bit stk, input bit inv, input int w, input bit poke);
    int nb, lat, pc, dc;
    logic [63:0] t, rx;
    logic [7:0] b;
    bit e;
    nb = n > 8 ? 8 : n;
    t = txd;
    rx = '0;
    e = 0;
    lat = 0;
    busy_n = bn;
    stuck = stk;
    rx_inv = inv;
    ws = w;
    if (nb > 0) exp_apb.push_back({1'b1, 16'h0040, 2'b00, m, s, k});
    for (int i = 0; i < nb && !e; i++) begin
      b = t[63:56];
      t = t << 8;
      exp_apb.push_back({1'b1, 16'h0044, b});
      exp_apb.push_back({1'b1, 16'h004C, 8'h02});
      for (int j = 0; j < (stk ? PMAX : bn + 1); j++) exp_apb.push_back({1'b0, 16'h0040, 8'h00});
      if (stk) e = 1;
      else begin
        exp_apb.push_back({1'b0, 16'h0044, 8'h00});
        rx = {rx[55:0], inv ? ~b : 8'h3C};
      end
    end
    exp_res.push_back({e, rx});
    @(negedge clk);
    pc = psel_cyc;
    dc = done_cnt;
    nbytes = n[3:0];
    tx_data = txd;
    mode = m;
    slave = s;
    sck = k;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 1) chk("busy_after_start", busy, 1);
      if (poke && lat == 30) begin
        start = 1'b1;
        nbytes = 4'd1;
        tx_data = '1;
        mode = 2'd3;
      end
    end while (!done && lat < 20000);
    if (!done) begin
      vecs++;
      errs++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
    end
    if (n == 0) chk("zero_done_latency", lat, 2);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - dc, 1);
    if (n == 0) chk("zero_psel_activity", psel_cyc - pc, 0);
    chk("apb_queue_drained", exp_apb.size(), 0);
    chk("busy_idle", busy, 0);
    exp_apb.delete();
    exp_res.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, err, rx_data, psel, penable, pwrite, paddr, pwdata}, 0);
    rst = 1'b0;
    sb_on = 1;
    burst(1, {8'hA5, 56'h0}, 2'd0, 2'd3, 2'd1, 0, 0, 0, 0, 0);
    burst(8, 64'h0123456789ABCD0F, 2'd1, 2'd2, 2'd3, 0, 0, 1, 0, 0);
    burst(2, {16'h5AC3, 48'h0}, 2'd2, 2'd1, 2'd0, 3, 0, 0, 0, 0);
    burst(15, 64'h0123456789ABCD0F, 2'd1, 2'd2, 2'd3, 0, 0, 1, 3, 0);
    burst(3, 64'hDEADBEEF00000000, 2'd3, 2'd0, 2'd2, 0, 1, 0, 0, 1);
    burst(0, 64'h1122334455667788, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
    burst(4, 64'h80FF1E7700000000, 2'd2, 2'd2, 2'd2, 1, 0, 1, 1, 0);
    sb_on = 0;
    nbytes = 4'd8;
    tx_data = 64'h0123456789ABCD0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_burst", {busy, done, err, rx_data, psel, penable, pwrite, paddr, pwdata}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", {busy, psel, done}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
